// File: rtl/riscv_pkg.sv
// Shared load/store definitions: funct3 access-size codes and the LSU state type.
package riscv_pkg;

    // funct3 encodings of load/store size, shared with the decoder
    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/riscv_lsu_align.sv
// Combinational lane logic for the LSU: byte enables, store replication,
// misalignment detection on the request side, and load extraction/extension
// on the response side. Unlisted size codes (3/6/7) behave as word accesses.
module riscv_lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  i_size,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_wd,
    output logic [3:0]  o_be,
    output logic [31:0] o_wd,
    output logic        o_misaligned,
    input  logic [2:0]  i_ld_size,
    input  logic [1:0]  i_ld_off,
    input  logic [31:0] i_rd,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Request side: lane enables, replicated store data and alignment check
    always_comb begin
        o_be         = 4'b1111;
        o_wd         = i_wd;
        o_misaligned = 1'b0;
        case (i_size)
            LDST_B, LDST_BU: begin
                o_be = 4'b0001 << i_off;
                o_wd = {4{i_wd[7:0]}};
            end
            LDST_H, LDST_HU: begin
                o_be         = 4'b0011 << i_off;
                o_wd         = {2{i_wd[15:0]}};
                o_misaligned = i_off[0];
            end
            default: begin
                o_misaligned = (i_off != 2'b00);
            end
        endcase
    end

    // Response side: pick the addressed byte/half out of the memory word
    always_comb begin
        w_half = i_ld_off[1] ? i_rd[31:16] : i_rd[15:0];
        case (i_ld_off)
            2'd0:    w_byte = i_rd[7:0];
            2'd1:    w_byte = i_rd[15:8];
            2'd2:    w_byte = i_rd[23:16];
            default: w_byte = i_rd[31:24];
        endcase
    end

    // Response side: sign- or zero-extend according to the latched size
    always_comb begin
        case (i_ld_size)
            LDST_B:  o_ld_data = {{24{w_byte[7]}}, w_byte};
            LDST_BU: o_ld_data = {24'd0, w_byte};
            LDST_H:  o_ld_data = {{16{w_half[15]}}, w_half};
            LDST_HU: o_ld_data = {16'd0, w_half};
            default: o_ld_data = i_rd;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit controller: sequences one data-memory access per core
// request through IDLE -> BUSY -> DONE, stalling the core until the access
// completes, is rejected as misaligned, or is abandoned by the watchdog.
module riscv_lsu
    import riscv_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_req_o,
    output logic        misaligned_o,
    output logic        bus_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    localparam int             CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit             TMO_EN = (TIMEOUT != 0);
    // Count value seen in the TIMEOUT-th BUSY cycle (count starts at 0)
    localparam logic [CNT_W-1:0] CNT_LAST = TMO_EN ? CNT_W'(TIMEOUT - 1) : '0;

    lsu_state_t       r_state;
    lsu_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_ld_size;
    logic [1:0]       r_ld_off;

    logic             w_launch;
    logic             w_abort_mis;
    logic             w_complete;
    logic             w_timeout;
    logic [3:0]       w_be;
    logic [31:0]      w_wd;
    logic             w_misaligned;
    logic [31:0]      w_ld_data;

    riscv_lsu_align u_align (
        .i_size       (core_size_i),
        .i_off        (core_addr_i[1:0]),
        .i_wd         (core_wd_i),
        .o_be         (w_be),
        .o_wd         (w_wd),
        .o_misaligned (w_misaligned),
        .i_ld_size    (r_ld_size),
        .i_ld_off     (r_ld_off),
        .i_rd         (mem_rd_i),
        .o_ld_data    (w_ld_data)
    );

    // The stall is released only while the access is retiring
    assign core_stall_req_o = core_req_i & (r_state != DONE);

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and one-cycle action strobes; ready beats the watchdog
    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_abort_mis = 1'b0;
        w_complete  = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                if (core_req_i && w_misaligned) begin
                    w_abort_mis = 1'b1;
                    w_state_nxt = DONE;
                end else if (core_req_i) begin
                    w_launch    = 1'b1;
                    w_state_nxt = BUSY;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            BUSY: begin
                if (mem_ready_i) begin
                    w_complete  = 1'b1;
                    w_state_nxt = DONE;
                end else if (TMO_EN && (r_cnt == CNT_LAST)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = BUSY;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Memory-side outputs, load result, watchdog counter and status pulses
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mem_req_o    <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_be_o     <= 4'd0;
            mem_addr_o   <= 32'd0;
            mem_wd_o     <= 32'd0;
            core_rd_o    <= 32'd0;
            misaligned_o <= 1'b0;
            bus_err_o    <= 1'b0;
            r_cnt        <= '0;
            r_ld_size    <= 3'd0;
            r_ld_off     <= 2'd0;
        end else begin
            misaligned_o <= w_abort_mis;
            bus_err_o    <= w_timeout;
            if (w_launch) begin
                mem_req_o  <= 1'b1;
                mem_we_o   <= core_we_i;
                mem_be_o   <= w_be;
                mem_addr_o <= {core_addr_i[31:2], 2'b00};
                mem_wd_o   <= w_wd;
                r_ld_size  <= core_size_i;
                r_ld_off   <= core_addr_i[1:0];
                r_cnt      <= '0;
            end else if (w_complete || w_timeout) begin
                mem_req_o <= 1'b0;
            end else if (TMO_EN && (r_state == BUSY)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_complete && !mem_we_o) begin
                core_rd_o <= w_ld_data;
            end
        end
    end

endmodule
